// File: rtl/flash_addr_if.sv
// Command, status and reader-facing signals of the flash address/timing controller.
interface flash_addr_if;
  logic        cmd_play;
  logic        cmd_pause;
  logic        cmd_fwd;
  logic        cmd_bwd;
  logic        cmd_restart;
  logic        spd_up;
  logic        spd_down;
  logic        spd_rst;
  logic        reader_finish;
  logic [22:0] address;
  logic        reader_start;
  logic        sample_tick;
  logic        playing;
  logic        dir_fwd;
  logic [15:0] period;

  modport master (
    output cmd_play, cmd_pause, cmd_fwd, cmd_bwd, cmd_restart,
    output spd_up, spd_down, spd_rst, reader_finish,
    input  address, reader_start, sample_tick, playing, dir_fwd, period
  );

  modport slave (
    input  cmd_play, cmd_pause, cmd_fwd, cmd_bwd, cmd_restart,
    input  spd_up, spd_down, spd_rst, reader_finish,
    output address, reader_start, sample_tick, playing, dir_fwd, period
  );
endinterface

// File: rtl/flash_addr_ctrl.sv
// Word address, reader start level and sample-rate tick for the flash reader.
// Define FLASH_ADDR_ONESHOT_EN to stop at the end of the song instead of looping.
module flash_addr_ctrl #(
  parameter logic [22:0] ADDR_START     = 23'h000000,
  parameter logic [22:0] ADDR_END       = 23'h07FFFF,
  parameter logic [15:0] PERIOD_DEFAULT = 16'd1136,
  parameter logic [15:0] PERIOD_STEP    = 16'd32,
  parameter logic [15:0] PERIOD_MIN     = 16'd256,
  parameter logic [15:0] PERIOD_MAX     = 16'd4096
) (
  input  logic         clk,
  input  logic         rst,
  flash_addr_if.slave  bus
);

  // state      | meaning
  // ST_IDLE    | after reset, waiting for the first play
  // ST_PLAYING | ticks running, address advancing per consumed word
  // ST_PAUSED  | tick counter frozen, reader stalls on its held sample
  // ST_ENDED   | end of song reached (one-shot builds only)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
`ifdef FLASH_ADDR_ONESHOT_EN
  localparam logic [1:0] ST_ENDED   = 2'd3;
`endif

  logic [1:0]  state, state_nxt;
  logic [22:0] address_q;
  logic [15:0] period_q, period_nxt, cnt_q;
  logic [16:0] period_sum, period_diff;
  logic        tick_q, start_q, playing_q, dir_q;
  logic        consumed, at_end, reload;

  assign consumed = tick_q && bus.reader_finish;
  assign at_end   = dir_q ? (address_q == ADDR_END) : (address_q == ADDR_START);

  always_comb begin
    state_nxt = state;
    reload    = bus.cmd_restart;
    case (state)
      ST_IDLE:    if (bus.cmd_play && !bus.cmd_pause) state_nxt = ST_PLAYING;
      ST_PLAYING: begin
        if (bus.cmd_pause) state_nxt = ST_PAUSED;
`ifdef FLASH_ADDR_ONESHOT_EN
        else if (consumed && at_end && !bus.cmd_restart) state_nxt = ST_ENDED;
`endif
      end
      ST_PAUSED:  if (bus.cmd_play && !bus.cmd_pause) state_nxt = ST_PLAYING;
`ifdef FLASH_ADDR_ONESHOT_EN
      ST_ENDED: begin
        // replay from the end always starts over at the top of the song
        if ((bus.cmd_play || bus.cmd_restart) && !bus.cmd_pause) begin
          state_nxt = ST_PLAYING;
          reload    = 1'b1;
        end
      end
`endif
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // 17-bit intermediates so a step past either end saturates instead of wrapping
  assign period_sum  = {1'b0, period_q} + {1'b0, PERIOD_STEP};
  assign period_diff = {1'b0, period_q} - {1'b0, PERIOD_STEP};

  always_comb begin
    period_nxt = period_q;
    if (bus.spd_rst)
      period_nxt = PERIOD_DEFAULT;
    else if (bus.spd_up)
      period_nxt = (period_diff[16] || period_diff < {1'b0, PERIOD_MIN}) ? PERIOD_MIN : period_diff[15:0];
    else if (bus.spd_down)
      period_nxt = (period_sum > {1'b0, PERIOD_MAX}) ? PERIOD_MAX : period_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      period_q  <= PERIOD_DEFAULT;
      playing_q <= 1'b0;
      start_q   <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      state     <= state_nxt;
      period_q  <= period_nxt;
      playing_q <= (state_nxt == ST_PLAYING);
      if (state_nxt == ST_PLAYING) start_q <= 1'b1;
      if (bus.cmd_fwd && !bus.cmd_bwd)      dir_q <= 1'b1;
      else if (bus.cmd_bwd && !bus.cmd_fwd) dir_q <= 1'b0;
    end
  end

  // Counting only when staying in PLAYING keeps the tick low on the pause/end edge.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else if (state == ST_PLAYING && state_nxt == ST_PLAYING) begin
      if (cnt_q >= period_q - 16'd1) begin
        cnt_q  <= 16'd0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 16'd1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address_q <= ADDR_START;
    end else if (reload) begin
      address_q <= dir_q ? ADDR_START : ADDR_END;
    end else if (consumed) begin
`ifdef FLASH_ADDR_ONESHOT_EN
      if (!at_end) address_q <= dir_q ? address_q + 23'd1 : address_q - 23'd1;
`else
      if (at_end)  address_q <= dir_q ? ADDR_START : ADDR_END;
      else         address_q <= dir_q ? address_q + 23'd1 : address_q - 23'd1;
`endif
    end
  end

  assign bus.address      = address_q;
  assign bus.reader_start = start_q;
  assign bus.sample_tick  = tick_q;
  assign bus.playing      = playing_q;
  assign bus.dir_fwd      = dir_q;
  assign bus.period       = period_q;

endmodule

// File: tb/tb_flash_addr_ctrl.sv
// Scoreboard bench for flash_addr_ctrl: reference model predicts every cycle, monitor compares at negedge.
module tb_flash_addr_ctrl;
  localparam int A_S = 0, A_E = 7;
  localparam int P_DEF = 4, P_STEP = 3, P_MIN = 2, P_MAX = 20;
`ifdef FLASH_ADDR_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_addr_if bus();

  flash_addr_ctrl #(
    .ADDR_START(23'(A_S)), .ADDR_END(23'(A_E)),
    .PERIOD_DEFAULT(16'(P_DEF)), .PERIOD_STEP(16'(P_STEP)),
    .PERIOD_MIN(16'(P_MIN)), .PERIOD_MAX(16'(P_MAX))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [22:0] address;
    logic        reader_start;
    logic        sample_tick;
    logic        playing;
    logic        dir_fwd;
    logic [15:0] period;
  } obs_t;

  typedef struct packed {
    bit rst, play, pause, fwd, bwd, restart, up, down, srst, rf;
  } stim_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: 0 idle, 1 playing, 2 paused, 3 ended
  int m_mode, m_cnt, m_per, m_addr;
  bit m_dir, m_tick, m_rs, m_play;

  function automatic void model_reset();
    m_mode = 0; m_cnt = 0; m_per = P_DEF; m_addr = A_S;
    m_dir = 1; m_tick = 0; m_rs = 0; m_play = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    int nm, n, off, na, np, nc;
    bit reload, consumed, at_end, nt;
    if (s.rst) begin
      model_reset();
      return;
    end
    n        = A_E - A_S + 1;
    off      = m_addr - A_S;
    consumed = m_tick && s.rf;
    at_end   = m_dir ? (m_addr == A_E) : (m_addr == A_S);
    reload   = s.restart;
    nm       = m_mode;
    if (m_mode == 0 && s.play && !s.pause) nm = 1;
    if (m_mode == 2 && s.play && !s.pause) nm = 1;
    if (m_mode == 1) begin
      if (s.pause) nm = 2;
      else if (ONESHOT && consumed && at_end && !s.restart) nm = 3;
    end
    if (m_mode == 3 && (s.play || s.restart) && !s.pause) begin
      nm = 1; reload = 1;
    end
    na = m_addr;
    if (reload) na = m_dir ? A_S : A_E;
    else if (consumed && !(ONESHOT && at_end))
      na = A_S + (m_dir ? (off + 1) % n : (off + n - 1) % n);
    nc = m_cnt; nt = 0;
    if (reload) nc = 0;
    else if (m_mode == 1 && nm == 1) begin
      if (m_cnt >= m_per - 1) begin nc = 0; nt = 1; end
      else nc = m_cnt + 1;
    end
    np = m_per;
    if (s.srst) np = P_DEF;
    else if (s.up) np = (m_per - P_STEP < P_MIN) ? P_MIN : m_per - P_STEP;
    else if (s.down) np = (m_per + P_STEP > P_MAX) ? P_MAX : m_per + P_STEP;
    if (s.fwd && !s.bwd) m_dir = 1;
    if (s.bwd && !s.fwd) m_dir = 0;
    m_mode = nm; m_addr = na; m_cnt = nc; m_tick = nt; m_per = np;
    m_play = (nm == 1);
    if (nm == 1) m_rs = 1;
  endfunction

  task automatic cyc(input stim_t s);
    obs_t e;
    rst = s.rst;
    bus.cmd_play = s.play;   bus.cmd_pause = s.pause;
    bus.cmd_fwd = s.fwd;     bus.cmd_bwd = s.bwd;
    bus.cmd_restart = s.restart;
    bus.spd_up = s.up;       bus.spd_down = s.down;   bus.spd_rst = s.srst;
    bus.reader_finish = s.rf;
    @(posedge clk);
    #1;
    model_step(s);
    e.address = 23'(m_addr); e.reader_start = m_rs; e.sample_tick = m_tick;
    e.playing = m_play;      e.dir_fwd = m_dir;     e.period = 16'(m_per);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance with base stimulus until the model shows a tick at the wanted address (-1 = any)
  task automatic wait_tick_at(input int want, input stim_t base);
    for (int i = 0; i < 200; i++) begin
      if (m_tick && (want < 0 || m_addr == want)) return;
      cyc(base);
    end
    chk("wait_tick_timeout", 0, 1);
  endtask

  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.address = bus.address;   a.reader_start = bus.reader_start;
      a.sample_tick = bus.sample_tick; a.playing = bus.playing;
      a.dir_fwd = bus.dir_fwd;   a.period = bus.period;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got addr=%0d start=%b tick=%b play=%b dir=%b per=%0d, expected addr=%0d start=%b tick=%b play=%b dir=%b per=%0d",
                 $time, a.address, a.reader_start, a.sample_tick, a.playing, a.dir_fwd, a.period,
                 e.address, e.reader_start, e.sample_tick, e.playing, e.dir_fwd, e.period);
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"}, int'(bus.address), A_S);
    chk({tag, "_period"}, int'(bus.period), P_DEF);
    chk({tag, "_dir"}, int'(bus.dir_fwd), 1);
    chk({tag, "_start"}, int'(bus.reader_start), 0);
    chk({tag, "_playing"}, int'(bus.playing), 0);
    chk({tag, "_tick"}, int'(bus.sample_tick), 0);
  endtask

  initial begin
    stim_t s;
    int ticks, n, saved;
    bit had, rf_ph;
    model_reset();
    s = '0; s.rst = 1;
    cyc(s); cyc(s);
    chk_reset_values("reset");

    s = '0; s.play = 1; s.rf = 1;
    cyc(s);
    chk("play_start", int'(bus.reader_start), 1);
    chk("play_playing", int'(bus.playing), 1);
    s.play = 0; ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(s);
      if (bus.sample_tick) ticks++;
      if (i == 3) chk("first_tick", int'(bus.sample_tick), 1);
    end
    chk("tick_count", ticks, 3);
    chk("addr_two", int'(bus.address), 2);

    // two ticks per word: reader_finish alternates 0/1 per tick
    rf_ph = 0;
    for (int i = 0; i < 40; i++) begin
      had = m_tick; s.rf = rf_ph;
      cyc(s);
      if (had) rf_ph = ~rf_ph;
    end
    chk("alt_addr", int'(bus.address), 7);

    s.rf = 1;
    wait_tick_at(A_E, s);
    cyc(s);
    if (ONESHOT) begin
      chk("end_hold_addr", int'(bus.address), A_E);
      chk("end_playing", int'(bus.playing), 0);
      ticks = 0;
      for (int i = 0; i < 10; i++) begin cyc(s); if (bus.sample_tick) ticks++; end
      chk("end_no_ticks", ticks, 0);
      s.play = 1; cyc(s); s.play = 0;
      chk("replay_addr", int'(bus.address), A_S);
      chk("replay_playing", int'(bus.playing), 1);
    end else begin
      chk("wrap_fwd", int'(bus.address), A_S);
    end

    s.bwd = 1; cyc(s); s.bwd = 0;
    chk("dir_bwd", int'(bus.dir_fwd), 0);
    wait_tick_at(-1, s); cyc(s);
    if (ONESHOT) begin
      chk("bwd_end_hold", int'(bus.address), A_S);
      chk("bwd_end_playing", int'(bus.playing), 0);
      s.play = 1; cyc(s); s.play = 0;
      chk("bwd_replay_addr", int'(bus.address), A_E);
    end else begin
      chk("wrap_bwd", int'(bus.address), A_E);
    end
    wait_tick_at(-1, s); cyc(s);
    chk("bwd_step", int'(bus.address), A_E - 1);

    s.fwd = 1; s.bwd = 1; cyc(s);
    chk("dir_both", int'(bus.dir_fwd), 0);
    s.bwd = 0; cyc(s); s.fwd = 0;
    chk("dir_fwd", int'(bus.dir_fwd), 1);

    s.rf = 0;
    s.up = 1; repeat (10) cyc(s); s.up = 0;
    chk("period_min", int'(bus.period), P_MIN);
    s.down = 1; repeat (10) cyc(s); s.down = 0;
    chk("period_max", int'(bus.period), P_MAX);
    s.srst = 1; s.up = 1; cyc(s); s.srst = 0; s.up = 0;
    chk("period_rst_wins", int'(bus.period), P_DEF);

    s.rf = 1; s.restart = 1; cyc(s); s.restart = 0;
    chk("restart_addr", int'(bus.address), A_S);
    wait_tick_at(5, s);
    s.restart = 1; cyc(s); s.restart = 0;
    chk("restart_beats_adv", int'(bus.address), A_S);

    n = 0;
    while (!(m_mode == 1 && m_cnt == 1) && n < 50) begin cyc(s); n++; end
    chk("pause_setup", int'(n < 50), 1);
    s.pause = 1; cyc(s); s.pause = 0;
    saved = m_addr; ticks = 0;
    for (int i = 0; i < 100; i++) begin cyc(s); if (bus.sample_tick) ticks++; end
    chk("pause_ticks", ticks, 0);
    chk("pause_addr", int'(bus.address), saved);
    s.play = 1; cyc(s); s.play = 0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(s); n++;
      if (bus.sample_tick) break;
    end
    chk("resume_latency", n, P_DEF - 1);

    s.rst = 1; cyc(s); s.rst = 0;
    chk_reset_values("midplay_rst");

    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(699, 0) == 0);
      s.play    = ($urandom_range(19, 0) == 0);
      s.pause   = ($urandom_range(39, 0) == 0);
      s.fwd     = ($urandom_range(29, 0) == 0);
      s.bwd     = ($urandom_range(29, 0) == 0);
      s.restart = ($urandom_range(59, 0) == 0);
      s.up      = ($urandom_range(24, 0) == 0);
      s.down    = ($urandom_range(24, 0) == 0);
      s.srst    = ($urandom_range(79, 0) == 0);
      s.rf      = ($urandom_range(1, 0) == 0);
      cyc(s);
    end

    s = '0;
    cyc(s); cyc(s);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_addr_ctrl.md
Name: flash_addr_ctrl

Overview:
- Address/timing controller sitting directly upstream of the flash reader FSM.
- Generates the 23-bit word address, the reader start level and the sample-rate tick (the reader's edge trigger).
- Steps the address once per consumed 32-bit word and applies keyboard commands: play, pause, forward, backward, restart and speed up/down/reset.

Parameters:
- ADDR_START, 23'h000000, first word address of the song region
- ADDR_END, 23'h07FFFF, last word address of the song region (ADDR_END > ADDR_START)
- PERIOD_DEFAULT, 16'd1136, clk cycles per sample tick after reset or speed reset
- PERIOD_STEP, 16'd32, period change per speed command
- PERIOD_MIN, 16'd256, lower clamp (fastest playback)
- PERIOD_MAX, 16'd4096, upper clamp (slowest playback)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_play  in  1  one-cycle pulse: start or resume playback
- cmd_pause  in  1  one-cycle pulse: pause playback
- cmd_fwd  in  1  one-cycle pulse: set forward direction
- cmd_bwd  in  1  one-cycle pulse: set backward direction
- cmd_restart  in  1  one-cycle pulse: jump to start of song in current direction
- spd_up  in  1  one-cycle pulse: period -= PERIOD_STEP
- spd_down  in  1  one-cycle pulse: period += PERIOD_STEP
- spd_rst  in  1  one-cycle pulse: period = PERIOD_DEFAULT
- reader_finish  in  1  reader is holding the second sample and waiting for a tick
- address  out  23  word address to the reader; must be stable in the cycle after a consumed tick
- reader_start  out  1  start level to the reader
- sample_tick  out  1  one-cycle sample-rate pulse (reader edge trigger)
- playing  out  1  high in PLAYING
- dir_fwd  out  1  1 = forward, 0 = backward
- period  out  16  current tick period

Behaviour:
- Reset values:
  - state = IDLE, address = ADDR_START, dir_fwd = 1, period = PERIOD_DEFAULT
  - reader_start = 0, sample_tick = 0, playing = 0, tick counter = 0
- State machine:
  - IDLE -> PLAYING on cmd_play.
  - PLAYING -> PAUSED on cmd_pause.
  - PAUSED -> PLAYING on cmd_play.
  - ENDED (exists only with the optional feature) -> PLAYING on cmd_play or cmd_restart.
- Same-cycle command priority: cmd_pause beats cmd_play.
- reader_start: registered; set to 1 on the first entry to PLAYING; stays 1 until rst.
- Tick generator:
  - 16-bit counter runs only in PLAYING and is frozen elsewhere.
  - When counter >= period-1: sample_tick = 1 for one cycle and the counter clears; otherwise the counter increments.
  - sample_tick is registered and is never high outside PLAYING. While paused the reader therefore stalls holding its sample.
- Word consumed: the clock edge where reader_finish && sample_tick.
  - Forward: address = (address == ADDR_END) ? ADDR_START : address+1.
  - Backward: address = (address == ADDR_START) ? ADDR_END : address-1.
  - The new address is visible the next cycle, which is when the reader latches it.
- sample_tick without reader_finish (the first sample of a word): address unchanged.
- cmd_restart: address = dir_fwd ? ADDR_START : ADDR_END. Accepted in any state; state unchanged. Wins over a same-cycle advance. Tick counter cleared.
- Direction commands:
  - cmd_fwd sets dir_fwd; cmd_bwd clears it.
  - Both in the same cycle: no change.
  - A direction change applies to the next advance; address is not modified.
- Speed commands:
  - Priority spd_rst > spd_up > spd_down.
  - Results are saturated to [PERIOD_MIN, PERIOD_MAX]; arithmetic uses 17 bits before clamping, with no wrap.
  - A new period takes effect immediately. If counter >= new period-1, the tick fires on the next cycle.
- Commands in IDLE: speed and direction commands are accepted and update dir_fwd and period.
- Reset mid-playback: all outputs return to reset values in the next cycle and reader_start drops. The reader must be reset on the same rst.

Optional Feature:
- Macro: FLASH_ADDR_ONESHOT_EN.
- Defined:
  - A word consumed at ADDR_END (forward) or ADDR_START (backward) does not wrap.
  - Address holds and state goes to ENDED; playing = 0 and ticks stop.
  - cmd_play from ENDED first reloads the address as for cmd_restart, then plays.
- Undefined: ENDED does not exist; address wraps as above (continuous loop).

Test Plan:
- Reset then cmd_play, PERIOD_DEFAULT=4, reader_finish tied 1:
  - reader_start rises 1 cycle after cmd_play.
  - sample_tick high every 4th cycle.
  - address 0 -> 1 -> 2 one cycle after each tick.
- reader_finish alternating 0/1 per tick: address advances only on ticks with reader_finish=1 (two ticks per word).
- Wrap, with ADDR_START=0, ADDR_END=3:
  - Forward from 3 -> 0.
  - cmd_bwd, then ticks: 0 -> 3 -> 2.
  - With FLASH_ADDR_ONESHOT_EN: forward at 3 -> ENDED, address stays 3, no ticks; cmd_play -> address 0, playing=1.
- cmd_pause mid-count: sample_tick stays 0 for 100 cycles and address holds. cmd_play: first tick occurs period-counter_at_pause cycles later.
- Speed clamps:
  - 40x spd_up from 1136 -> period 256.
  - 200x spd_down -> 4096.
  - spd_rst together with spd_up -> 1136.
- Simultaneous events:
  - cmd_restart in the same cycle as a consumed tick at address 5 (forward) -> address 0.
  - cmd_fwd with cmd_bwd -> dir_fwd unchanged.
  - rst during PLAYING -> all reset values next cycle.
